// File: rtl/hex_scroll_reader.sv
// hex_scroll_reader
// Loopback observer for the three-digit scrolling message display. It watches
// the active-low 7-segment buses, filters out short glitches, recovers the
// 2-bit character codes and checks every accepted change against a one-digit
// left rotation. It also reports the cycle count between rotation steps.
//
// Pipeline:
//   HEX buses -> sample register -> run-length filter -> qualify pulse
//             -> glyph decode + rotation compare -> registered outputs
// Every output is a flop, so the HEX inputs reach no output combinationally.

module hex_scroll_reader #(
   parameter int STABLE_CYCLES = 4,   // identical samples needed to accept a pattern (>= 2)
   parameter int CNT_W         = 28   // width of the step-interval counter and of period
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [6:0]       HEX0,
   input  logic [6:0]       HEX1,
   input  logic [6:0]       HEX2,
   output logic [5:0]       frame,
   output logic             frame_valid,
   output logic             step,
   output logic             rot_err,
   output logic             sym_err,
   output logic [CNT_W-1:0] period
);

   // ------------------------------------------------------------------
   // Local parameters and types
   // ------------------------------------------------------------------
   localparam int             RUN_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   typedef enum logic {
      S_IDLE  = 1'b0,   // no legal frame accepted yet
      S_TRACK = 1'b1    // following the rotation of an accepted frame
   } state_t;

   // Segment pattern to {legal, code}. Patterns are active-low, so the
   // blank digit is all ones.
   function automatic logic [2:0] glyph_decode(input logic [6:0] seg);
      logic [2:0] res;
      res = 3'b000;
      case (seg)
         7'h21:   res = 3'b1_00;   // 'd'
         7'h06:   res = 3'b1_01;   // 'E'
         7'h79:   res = 3'b1_10;   // '1'
         7'h7F:   res = 3'b1_11;   // blank
         default: res = 3'b0_00;   // anything else is not a glyph
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------------
   // Input sampling and glitch filter
   // ------------------------------------------------------------------
   logic [20:0]      hex_in;
   logic [20:0]      sample_q;
   logic [RUN_W-1:0] run_q;
   logic [RUN_W-1:0] run_d;
   logic             qual_d;
   logic             qual_q;
   logic [20:0]      qual_smp_q;

   assign hex_in = {HEX2, HEX1, HEX0};

   // Run length of identical samples; a new value restarts at one and the
   // count parks at STABLE_CYCLES while the pattern holds.
   always_comb begin
      run_d = run_q;
      if (hex_in != sample_q) begin
         run_d = RUN_ONE;
      end else if (run_q != RUN_MAX) begin
         run_d = run_q + RUN_ONE;
      end
   end

   // Qualify only on the transition into saturation: one event per pattern.
   assign qual_d = (run_d == RUN_MAX) && (run_q != RUN_MAX);

   // Sample register, run counter and the captured qualifying pattern.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sample_q   <= '0;
         run_q      <= '0;
         qual_q     <= 1'b0;
         qual_smp_q <= '0;
      end else begin
         sample_q <= hex_in;
         run_q    <= run_d;
         qual_q   <= qual_d;
         if (qual_d) begin
            qual_smp_q <= hex_in;
         end
      end
   end

   // ------------------------------------------------------------------
   // Glyph decode of the qualified pattern
   // ------------------------------------------------------------------
   logic [2:0] dec2;
   logic [2:0] dec1;
   logic [2:0] dec0;
   logic       dec_legal;
   logic [5:0] dec_frame;

   // Decode each digit of the captured pattern and merge the legal flags.
   always_comb begin
      dec2      = glyph_decode(qual_smp_q[20:14]);
      dec1      = glyph_decode(qual_smp_q[13:7]);
      dec0      = glyph_decode(qual_smp_q[6:0]);
      dec_legal = dec2[2] & dec1[2] & dec0[2];
      dec_frame = {dec2[1:0], dec1[1:0], dec0[1:0]};
   end

   // ------------------------------------------------------------------
   // Tracking state machine and interval counter
   // ------------------------------------------------------------------
   state_t           state_q;
   state_t           state_d;
   logic [5:0]       frame_q;
   logic [5:0]       frame_d;
   logic             fv_q;
   logic             fv_d;
   logic             step_q;
   logic             step_d;
   logic             rot_q;
   logic             rot_d;
   logic             sym_q;
   logic             sym_d;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] period_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [5:0]       frame_rotl;

   // Saturating increment: the counter parks at all-ones instead of wrapping.
   always_comb begin
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   end

   // Expected next frame: every digit moves one place left, the leftmost
   // code wraps round to the right.
   assign frame_rotl = {frame_q[3:2], frame_q[1:0], frame_q[5:4]};

   // Next-state and output decisions, taken only on a qualify event.
   // period is loaded with the incremented count so that it equals the
   // number of edges between the clearing edge and the step edge.
   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      fv_d     = fv_q;
      step_d   = 1'b0;
      rot_d    = 1'b0;
      sym_d    = 1'b0;
      period_d = period_q;
      cnt_d    = (state_q == S_TRACK) ? cnt_inc : cnt_q;

      if (qual_q) begin
         if (!dec_legal) begin
            // Bad glyph: report it and leave the tracking context alone.
            sym_d = 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  frame_d = dec_frame;
                  fv_d    = 1'b1;
                  state_d = S_TRACK;
                  cnt_d   = '0;
               end
               S_TRACK: begin
                  if (dec_frame == frame_q) begin
                     // Held phase, or a glitch that came back: nothing to do.
                     frame_d = frame_q;
                  end else if (dec_frame == frame_rotl) begin
                     step_d   = 1'b1;
                     period_d = cnt_inc;
                     frame_d  = dec_frame;
                     cnt_d    = '0;
                  end else begin
                     // Legal but unexpected: flag it and resynchronise.
                     rot_d   = 1'b1;
                     frame_d = dec_frame;
                     cnt_d   = '0;
                  end
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
      end
   end

   // State, counter and output registers.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= S_IDLE;
         frame_q  <= '0;
         fv_q     <= 1'b0;
         step_q   <= 1'b0;
         rot_q    <= 1'b0;
         sym_q    <= 1'b0;
         period_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         fv_q     <= fv_d;
         step_q   <= step_d;
         rot_q    <= rot_d;
         sym_q    <= sym_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

   assign frame       = frame_q;
   assign frame_valid = fv_q;
   assign step        = step_q;
   assign rot_err     = rot_q;
   assign sym_err     = sym_q;
   assign period      = period_q;

endmodule

// File: doc/hex_scroll_reader.md
# hex_scroll_reader

Observer for the three-digit scrolling character display. It watches the active-low 7-segment buses HEX2/HEX1/HEX0 driven by the rotating-message block and recovers the 2-bit character codes. It checks every change against the expected left rotation and measures the interval between scroll steps. It sits beside the display path as a self-check and loopback receiver for the scrolling-message lab.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a display pattern is accepted (glitch filter). Legal range is 2 or more.
- CNT_W, 28: width of the step-interval counter and of `period`.

- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- HEX0  in  7  rightmost digit segments. Active-low; bit i is segment i.
- HEX1  in  7  middle digit segments.
- HEX2  in  7  leftmost digit segments.
- frame  out  6  accepted codes {HEX2 code, HEX1 code, HEX0 code}. HEX2 code is in [5:4].
- frame_valid  out  1  high once a first legal frame has been accepted.
- step  out  1  one-cycle pulse on a legal rotation.
- rot_err  out  1  one-cycle pulse on a legal but non-rotation change.
- sym_err  out  1  one-cycle pulse when a stable pattern is not a legal glyph.
- period  out  CNT_W  clock cycles between the last two step events.

## Operation
- Glyph decode, per digit, 7-bit [6:0] value to code:
  - 7'h21 ('d') -> 00
  - 7'h06 ('E') -> 01
  - 7'h79 ('1') -> 10
  - 7'h7F (blank) -> 11
  - any other value is illegal.
- Input filter:
  - The three buses are registered together as one 21-bit sample.
  - run_len counts consecutive equal samples, saturating at STABLE_CYCLES.
  - Any differing sample resets run_len to 1.
  - A qualify event fires only on the cycle run_len first reaches STABLE_CYCLES, so one event per stable pattern.
- Qualify event when any digit is illegal:
  - sym_err pulses.
  - frame, frame_valid, state and the interval counter are unchanged.
- State machine, two states: IDLE and TRACK.
- IDLE, legal qualify:
  - frame <= decoded; frame_valid <= 1; state -> TRACK.
  - Interval counter cleared; no step.
- TRACK, legal qualify, compare decoded value D with R = rotl(frame) = {frame[3:2], frame[1:0], frame[5:4]}:
  - D == frame: no action. This covers a glitch that returned to the old value, and the held phase of the scroll.
  - D == R and D != frame: step pulses; period <= interval counter; frame <= D; counter cleared.
  - Otherwise: rot_err pulses; frame <= D (resynchronise); counter cleared; period unchanged.
- Uniform frames (all three codes equal): rotl equals frame, so they never produce step or rot_err.
- Interval counter:
  - Increments every cycle in TRACK.
  - Saturates at all-ones and never wraps.
  - Saturated value is reported as-is in period.
- Simultaneous events are impossible by construction: at most one of step, rot_err, sym_err is high in any cycle.

## Timing
- Reset values, applied on the first rising edge with reset high:
  - frame = 0, frame_valid = 0, step = 0, rot_err = 0, sym_err = 0, period = 0.
  - state = IDLE, run_len = 0, interval counter = 0, sample register = 0.
- Reset mid-operation discards any partially filtered pattern. A display held constant through reset re-qualifies STABLE_CYCLES+1 edges after reset falls.
- Latency: input stable from edge t means outputs update on edge t+STABLE_CYCLES+1. step, rot_err and sym_err are high for exactly that one cycle.
- Patterns shorter than STABLE_CYCLES cycles are ignored completely.
- period equals the number of cycles between the two step-producing edges. Filter latency is identical for both edges, so period equals the true display step interval.
- All outputs are registered; there is no combinational path from the HEX inputs.

## Test plan
- Reset, then all digits 7'h7F for 10 cycles -> frame = 6'b111111 and frame_valid = 1 on edge 5 after release; no step or rot_err.
- (HEX2,HEX1,HEX0) = (21,06,79) held, then (06,79,21) held -> frame = 00_01_10, then exactly one step pulse and frame = 01_10_00; rot_err and sym_err stay 0.
- From frame 00_01_10, HEX1 = 7'h00 for 2 cycles then restored -> no sym_err, step or rot_err; frame unchanged.
- HEX1 = 7'h00 held 20 cycles -> exactly one sym_err pulse; frame and frame_valid unchanged.
- From 00_01_10, apply (79,06,21) = 10_01_00 -> one rot_err pulse, frame = 10_01_00, no step, period unchanged.
- Legal rotations spaced 100 cycles apart -> period = 100 after the second step. Assert reset for 1 cycle mid-interval -> all outputs 0 on the next edge and frame_valid = 0 until a new qualify.
